traffic_intersection_ctrl: RTL and testbench

TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

---
 rtl/traffic_pkg.sv | 46 ++++
 rtl/traffic_intersection_ctrl_phase_timer.sv | 38 +++
 rtl/traffic_intersection_ctrl.sv | 146 ++++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared types and constants for the traffic intersection controller:
//   - state_t      : the six-phase signal cycle
//   - light_t      : {red,yellow,green} one-hot lamp code and its three values
//   - DEF_T_*      : default phase durations in clock cycles
//   - main_lamp / side_lamp : Moore lamp decode from the phase state
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5
  } state_t;

  typedef logic [2:0] light_t;

  localparam light_t LIGHT_RED    = 3'b100;
  localparam light_t LIGHT_YELLOW = 3'b010;
  localparam light_t LIGHT_GREEN  = 3'b001;

  localparam int unsigned DEF_T_MAIN_GREEN = 60;
  localparam int unsigned DEF_T_SIDE_GREEN = 30;
  localparam int unsigned DEF_T_YELLOW     = 5;
  localparam int unsigned DEF_T_ALL_RED    = 2;
  localparam int unsigned DEF_T_SHORT      = 10;

  function automatic light_t main_lamp(input state_t s);
    case (s)
      MAIN_GREEN:  return LIGHT_GREEN;
      MAIN_YELLOW: return LIGHT_YELLOW;
      default:     return LIGHT_RED;
    endcase
  endfunction

  function automatic light_t side_lamp(input state_t s);
    case (s)
      SIDE_GREEN:  return LIGHT_GREEN;
      SIDE_YELLOW: return LIGHT_YELLOW;
      default:     return LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_phase_timer.sv
// phase_timer
// 8-bit loadable down-counter holding the remaining cycles of the current
// phase. A load takes priority over counting; the count stops at 1 and never
// wraps below it.
// Ports:
//   clk        : clock
//   rst        : asynchronous active-high reset, loads RST_VAL
//   i_load     : load strobe
//   i_load_val : value loaded when i_load is high
//   o_count    : current counter value
//   o_is_one   : high when the counter equals 1 (last cycle of the phase)
module phase_timer #(
  parameter logic [7:0] RST_VAL = 8'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic [7:0] o_count,
  output logic       o_is_one
);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count > 8'd1) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_count  = r_count;
  assign o_is_one = (r_count == 8'd1);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl
// Two-road intersection controller. The main road rests in green; a side-road
// vehicle or a pedestrian request shortens the remaining main green to at most
// T_SHORT cycles and then runs one full side-road cycle.
// Ports:
//   clk        : clock, all state changes on its rising edge
//   rst        : asynchronous active-high reset (forces ALL_RED_B)
//   side_car   : side-road vehicle sensor (level or pulse)
//   ped_req    : pedestrian request to cross the main road (level or pulse)
//   main_light : main-road lamps {red,yellow,green}, one-hot
//   side_light : side-road lamps {red,yellow,green}, one-hot
//   clock      : remaining cycles in the current phase (N..1)
//   ped_walk   : walk indication, only during a granted SIDE_GREEN
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned T_MAIN_GREEN = DEF_T_MAIN_GREEN,
  parameter int unsigned T_SIDE_GREEN = DEF_T_SIDE_GREEN,
  parameter int unsigned T_YELLOW     = DEF_T_YELLOW,
  parameter int unsigned T_ALL_RED    = DEF_T_ALL_RED,
  parameter int unsigned T_SHORT      = DEF_T_SHORT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_car,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [7:0] clock,
  output logic       ped_walk
);

  localparam logic [7:0] L_MAIN_GREEN = 8'(T_MAIN_GREEN);
  localparam logic [7:0] L_SIDE_GREEN = 8'(T_SIDE_GREEN);
  localparam logic [7:0] L_YELLOW     = 8'(T_YELLOW);
  localparam logic [7:0] L_ALL_RED    = 8'(T_ALL_RED);
  localparam logic [7:0] L_SHORT      = 8'(T_SHORT);

  state_t     r_state;
  logic       r_pending;
  logic       r_walk_granted;

  state_t     w_next_state;
  logic       w_load;
  logic [7:0] w_load_val;
  logic [7:0] w_timer;
  logic       w_is_one;
  logic       w_req;
  logic       w_enter_side_green;

  function automatic logic [7:0] phase_len(input state_t s);
    case (s)
      MAIN_GREEN:  return L_MAIN_GREEN;
      MAIN_YELLOW: return L_YELLOW;
      SIDE_GREEN:  return L_SIDE_GREEN;
      SIDE_YELLOW: return L_YELLOW;
      default:     return L_ALL_RED;
    endcase
  endfunction

  phase_timer #(
    .RST_VAL (L_ALL_RED)
  ) u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_count    (w_timer),
    .o_is_one   (w_is_one)
  );

  // A request seen on this very cycle counts as well as a stored one, so a
  // sensor pulse on the last main-green cycle still ends the phase.
  assign w_req = r_pending | side_car | ped_req;

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = 8'd0;
    case (r_state)
      MAIN_GREEN: begin
        if (w_is_one) begin
          w_load = 1'b1;
          if (w_req) begin
            w_next_state = MAIN_YELLOW;
            w_load_val   = L_YELLOW;
          end else begin
            // Nobody waiting: rest in main green for another full period.
            w_load_val   = L_MAIN_GREEN;
          end
        end else if (w_req && (w_timer > L_SHORT)) begin
          w_load     = 1'b1;
          w_load_val = L_SHORT;
        end
      end
      MAIN_YELLOW, ALL_RED_A, SIDE_GREEN, SIDE_YELLOW, ALL_RED_B: begin
        if (w_is_one) begin
          case (r_state)
            MAIN_YELLOW: w_next_state = ALL_RED_A;
            ALL_RED_A:   w_next_state = SIDE_GREEN;
            SIDE_GREEN:  w_next_state = SIDE_YELLOW;
            SIDE_YELLOW: w_next_state = ALL_RED_B;
            default:     w_next_state = MAIN_GREEN;
          endcase
          w_load     = 1'b1;
          w_load_val = phase_len(w_next_state);
        end
      end
      default: begin
        w_next_state = ALL_RED_B;
        w_load       = 1'b1;
        w_load_val   = L_ALL_RED;
      end
    endcase
  end

  assign w_enter_side_green = (w_next_state == SIDE_GREEN) && (r_state != SIDE_GREEN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ALL_RED_B;
      r_pending      <= 1'b0;
      r_walk_granted <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_enter_side_green) begin
        // Requests are being served now; walk is granted only if one was stored.
        r_pending      <= 1'b0;
        r_walk_granted <= r_pending;
      end else begin
        if ((r_state != SIDE_GREEN) && (side_car || ped_req)) begin
          r_pending <= 1'b1;
        end
        if ((r_state == SIDE_GREEN) && (w_next_state != SIDE_GREEN)) begin
          r_walk_granted <= 1'b0;
        end
      end
    end
  end

  assign main_light = main_lamp(r_state);
  assign side_light = side_lamp(r_state);
  assign clock      = w_timer;
  assign ped_walk   = (r_state == SIDE_GREEN) && r_walk_granted;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb_traffic_intersection_ctrl
// Directed-vector bench for traffic_intersection_ctrl with default durations.
module tb_traffic_intersection_ctrl;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side_car = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic [7:0] clock;
  logic       ped_walk;

  int n_err = 0;
  int n_chk = 0;

  traffic_intersection_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .side_car   (side_car),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .clock      (clock),
    .ped_walk   (ped_walk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks a whole phase: n cycles with clock counting n..1, then steps past it.
  task automatic expect_phase(input string tag, input logic [2:0] ml, input logic [2:0] sl,
                              input int n, input logic walk);
    for (int i = n; i >= 1; i--) begin
      check({tag, ".clock"}, int'(clock), i);
      check({tag, ".main"},  int'(main_light), int'(ml));
      check({tag, ".side"},  int'(side_light), int'(sl));
      check({tag, ".walk"},  int'(ped_walk), int'(walk));
      step();
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.clock", int'(clock), 2);
    check("rst.main",  int'(main_light), int'(RED));
    check("rst.side",  int'(side_light), int'(RED));
    check("rst.walk",  int'(ped_walk), 0);
    rst = 1'b0;

    // Idle: all-red 2..1, main green 60..1, reload to 60
    expect_phase("idle_ar", RED, RED, 2, 1'b0);
    expect_phase("idle_mg", GRN, RED, 60, 1'b0);
    check("reload.clock", int'(clock), 60);
    check("reload.main",  int'(main_light), int'(GRN));
    check("reload.side",  int'(side_light), int'(RED));

    // Side car at clock 45 clamps to 10
    repeat (15) step();
    check("clamp.pre", int'(clock), 45);
    side_car = 1'b1;
    step();
    side_car = 1'b0;
    expect_phase("clamp_mg", GRN, RED, 10, 1'b0);
    expect_phase("clamp_my", YEL, RED, 5, 1'b0);
    expect_phase("clamp_ara", RED, RED, 2, 1'b0);
    expect_phase("clamp_sg", RED, GRN, 30, 1'b1);
    expect_phase("clamp_sy", RED, YEL, 5, 1'b0);
    expect_phase("clamp_arb", RED, RED, 2, 1'b0);
    check("back.clock", int'(clock), 60);
    check("back.main",  int'(main_light), int'(GRN));

    // Side car at clock 7: no clamp
    repeat (53) step();
    check("noclamp.pre", int'(clock), 7);
    side_car = 1'b1;
    step();
    side_car = 1'b0;
    expect_phase("noclamp_mg", GRN, RED, 6, 1'b0);
    expect_phase("noclamp_my", YEL, RED, 5, 1'b0);
    expect_phase("noclamp_ara", RED, RED, 2, 1'b0);
    expect_phase("noclamp_sg", RED, GRN, 30, 1'b1);

    // Pedestrian request during side yellow
    ped_req = 1'b1;
    expect_phase("ped_sy", RED, YEL, 5, 1'b0);
    ped_req = 1'b0;
    expect_phase("ped_arb", RED, RED, 2, 1'b0);
    check("ped.entry60", int'(clock), 60);
    check("ped.entrymain", int'(main_light), int'(GRN));
    step();
    expect_phase("ped_mg", GRN, RED, 10, 1'b0);
    expect_phase("ped_my", YEL, RED, 5, 1'b0);
    expect_phase("ped_ara", RED, RED, 2, 1'b0);
    expect_phase("ped_sg", RED, GRN, 30, 1'b1);
    expect_phase("ped_sy2", RED, YEL, 5, 1'b0);
    expect_phase("ped_arb2", RED, RED, 2, 1'b0);
    // Pending was cleared at side-green entry, so no clamp this time
    check("cleared.60", int'(clock), 60);
    step();
    check("cleared.59", int'(clock), 59);

    // Side car exactly at clock 1
    repeat (58) step();
    check("last.pre", int'(clock), 1);
    check("last.premain", int'(main_light), int'(GRN));
    side_car = 1'b1;
    step();
    side_car = 1'b0;
    expect_phase("last_my", YEL, RED, 5, 1'b0);
    expect_phase("last_ara", RED, RED, 2, 1'b0);

    // Reset mid side green at clock 17
    repeat (13) step();
    check("midrst.pre", int'(clock), 17);
    check("midrst.preside", int'(side_light), int'(GRN));
    check("midrst.prewalk", int'(ped_walk), 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.clock", int'(clock), 2);
    check("midrst.main",  int'(main_light), int'(RED));
    check("midrst.side",  int'(side_light), int'(RED));
    check("midrst.walk",  int'(ped_walk), 0);
    step();
    rst = 1'b0;
    expect_phase("post_ar", RED, RED, 2, 1'b0);
    expect_phase("post_mg", GRN, RED, 60, 1'b0);
    check("post.reload", int'(clock), 60);
    check("post.side",   int'(side_light), int'(RED));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
